ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one 1024x8 single-port RAM between two requesters, port A and port B.
- Arbitrates round-robin with a bounded burst allowance.
- Registers the RAM command and routes read data back to the requester that issued the read, tagged by a pipeline owner bit.
- Sits directly in front of the RAM; requesters never drive RAM pins.

Parameters:
- ADDR_W, 10, RAM address width (1024 locations).
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, max consecutive grants to one port while the other is requesting (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held with its command until granted.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A transfer accepted this cycle (combinational from req and state).
- a_rvalid  out  1  port A read data valid, one-cycle pulse.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  (same as A)  port B equivalents.
- ram_wr  out  1  RAM write strobe, registered.
- ram_rd  out  1  RAM read strobe, registered.
- ram_add  out  ADDR_W  RAM address, registered.
- ram_din  out  DATA_W  RAM write data, registered.
- ram_dout  in  DATA_W  RAM read data; valid the cycle after ram_rd.

Behaviour:
- Reset (async assert, sync release):
  - ram_wr, ram_rd, a_rvalid, b_rvalid = 0.
  - ram_add, ram_din, a_rdata, b_rdata = 0.
  - owner = A, burst_cnt = 0.
  - In-flight reads are dropped; no rvalid is ever issued for them.
- Transfer: occurs on a cycle where x_req & x_gnt = 1. At most one of a_gnt/b_gnt is high in any cycle.
- Grant rules, evaluated each cycle:
  - Neither requesting: no grant; owner and burst_cnt hold.
  - Only one requesting: it is granted every cycle with no bubble. owner := that port. burst_cnt := 1 if owner changed, else saturating increment.
  - Both requesting, owner's burst_cnt < MAX_BURST: grant owner, burst_cnt += 1.
  - Both requesting, burst_cnt == MAX_BURST: grant the other port, owner := other, burst_cnt := 1.
  - Both requesting immediately after reset: A is granted first.
- State is the owner bit plus a 4-bit burst_cnt. It is equivalent to FSM states OWN_A and OWN_B, each with an embedded counter.
- Pipeline, with transfer in cycle N:
  - Cycle N+1: ram_add/ram_din = captured addr/wdata; ram_wr = we; ram_rd = ~we; tag_q = granted port.
  - Cycle N+2 (reads only): x_rdata = ram_dout and x_rvalid = 1 for the tagged port only, for exactly one cycle. The other port's rdata holds its previous value.
  - Cycle N+1 with no transfer in N: ram_wr = ram_rd = 0; ram_add/ram_din hold.
- Latency and throughput:
  - Read latency: 2 cycles from grant to rvalid.
  - Write completes in RAM at end of cycle N+1.
  - Throughput: one transfer per cycle, sustained across port switches.
- Ordering:
  - Operations reach the RAM in grant order.
  - A read granted the cycle after a write to the same address returns the new data, because the RAM sees the write first. No bypass logic.
- Boundaries:
  - Address 1023 vs 0: no wrap logic; addresses pass through unchanged.
  - req dropped without a grant: treated as withdrawn, no side effect.
  - Changing command fields while req = 1 and ungranted is legal; the values sampled at the grant cycle are used.
  - MAX_BURST = 1: strict alternation under contention.
  - rst_n asserted mid-burst: all outputs clear immediately, independent of clk.

Test Plan:
- Reset then idle: rst_n = 0 mid-stream -> ram_wr = ram_rd = 0, rvalids = 0, rdata = 0 without a clock edge; after release the first contended grant goes to A.
- A writes 0x5A to 0x3FF, then reads 0x3FF -> ram_wr high 1 cycle after the write grant; a_rvalid pulses 2 cycles after the read grant with a_rdata = 0x5A; b_rvalid stays 0.
- Both ports request continuous reads, MAX_BURST = 4 -> grant sequence AAAABBBBAAAA; rvalid sequence is identical, delayed 2 cycles; no idle RAM cycle.
- B writes 0x11 to 0x000 granted cycle N, A reads 0x000 granted cycle N+1 -> a_rdata = 0x11 in cycle N+3.
- Only B requests for 10 cycles with MAX_BURST = 2 -> b_gnt high all 10 cycles; burst_cnt saturates and does not block B.
- A read is granted in cycle N and rst_n pulses low in cycle N+1 -> no a_rvalid in cycle N+2; a_rdata = 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Purpose : one requester's command/response bundle for ram_port_arbiter.
// Ports   : req/we/addr/wdata (requester -> arbiter), gnt/rvalid/rdata (arbiter -> requester).
// Modports: master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Purpose : shares one single-port RAM between requesters A and B, round-robin with a
//           bounded burst allowance; read data is routed back by a pipeline owner tag.
// Latency : RAM command registered 1 cycle after grant; rvalid/rdata 2 cycles after grant.
// Backpressure: requester holds req+command until gnt; gnt is combinational, one transfer/cycle.
// Ports   : clk, rst_n (async active-low); a, b = requester interfaces (slave modport);
//           ram_wr/ram_rd/ram_add/ram_din = registered RAM command; ram_dout = RAM read data
//           (valid the cycle after ram_rd).
module ram_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave a,
  ram_port_arbiter_if.slave b,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_t;

  owner_t            owner;
  logic [3:0]        burst_cnt;
  logic              gnt_a;
  logic              gnt_b;
  logic              xfer;
  logic              keep;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  owner_t            tag_q;
  logic              a_rv_q;
  logic              b_rv_q;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] b_hold;

  // Grant: under contention the owner keeps the RAM until it has used its burst
  // allowance, then the other port takes over. An uncontended port always wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    keep  = (burst_cnt < MAX_B);
    if (a.req && b.req) begin
      if (owner == OWN_A) begin
        gnt_a = keep;
        gnt_b = ~keep;
      end else begin
        gnt_b = keep;
        gnt_a = ~keep;
      end
    end else begin
      gnt_a = a.req;
      gnt_b = b.req;
    end
  end

  assign xfer = gnt_a | gnt_b;

  always_comb begin
    cmd_we    = a.we;
    cmd_addr  = a.addr;
    cmd_wdata = a.wdata;
    if (gnt_b) begin
      cmd_we    = b.we;
      cmd_addr  = b.addr;
      cmd_wdata = b.wdata;
    end
  end

  assign a.gnt = gnt_a;
  assign b.gnt = gnt_b;

  // Ownership state: OWN_A / OWN_B with an embedded saturating burst counter.
  // Counter is only compared with '<', so saturating above MAX_BURST is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_A;
      burst_cnt <= 4'd0;
    end else if (xfer) begin
      if (gnt_b == (owner == OWN_B)) begin
        if (burst_cnt != 4'hF) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        owner     <= gnt_b ? OWN_B : OWN_A;
        burst_cnt <= 4'd1;
      end
    end
  end

  // RAM command stage and read-return stage. Clearing ram_rd on reset is what
  // drops in-flight reads: no rvalid can follow a cleared strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr  <= 1'b0;
      ram_rd  <= 1'b0;
      ram_add <= '0;
      ram_din <= '0;
      tag_q   <= OWN_A;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
      a_hold  <= '0;
      b_hold  <= '0;
    end else begin
      ram_wr <= xfer & cmd_we;
      ram_rd <= xfer & ~cmd_we;
      if (xfer) begin
        ram_add <= cmd_addr;
        ram_din <= cmd_wdata;
        tag_q   <= gnt_b ? OWN_B : OWN_A;
      end
      a_rv_q <= ram_rd && (tag_q == OWN_A);
      b_rv_q <= ram_rd && (tag_q == OWN_B);
      if (a_rv_q) a_hold <= ram_dout;
      if (b_rv_q) b_hold <= ram_dout;
    end
  end

  // RAM data arrives in the rvalid cycle itself, so it is forwarded directly
  // and also captured so rdata holds until that port's next read returns.
  assign a.rvalid = a_rv_q;
  assign b.rvalid = b_rv_q;
  assign a.rdata  = a_rv_q ? ram_dout : a_hold;
  assign b.rdata  = b_rv_q ? ram_dout : b_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose : self-checking bench for ram_port_arbiter with a behavioural RAM and reference model.
// Ports   : none (top-level bench); drives two requester interfaces and models the RAM.
// Flow    : table vectors, hand-written corner sequences, then randomized traffic.
module tb_ram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          rst_n;
  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = 8'h00;
  logic [DW-1:0] ram_mem [0:1023] = '{default: 8'h00};

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a_if),
    .b       (b_if),
    .ram_wr  (ram_wr),
    .ram_rd  (ram_rd),
    .ram_add (ram_add),
    .ram_din (ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: data read at the edge ending the ram_rd cycle.
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_add] <= ram_din;
    if (ram_rd) ram_dout <= ram_mem[ram_add];
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: memory contents in grant order, owner and run length of grants.
  logic [DW-1:0] m_mem [0:1023] = '{default: 8'h00};
  logic          m_owner;
  int            m_run;
  logic          e_wr, e_rd, e_arv, e_brv;
  logic [AW-1:0] e_add;
  logic [DW-1:0] e_din, e_ard, e_brd;
  logic          p_vld, p_port;
  logic [DW-1:0] p_dat;

  logic          obs_ga, obs_gb, obs_wr, obs_rd, obs_arv, obs_brv;
  logic [AW-1:0] obs_add;
  logic [DW-1:0] obs_din, obs_ard, obs_brd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 1'b0; m_run = 0;
    e_wr = 0; e_rd = 0; e_add = '0; e_din = '0;
    e_arv = 0; e_brv = 0; e_ard = '0; e_brd = '0;
    p_vld = 0; p_port = 0; p_dat = '0;
  endtask

  // Called at the falling edge: compare this cycle, then advance the model one cycle.
  task automatic step_model();
    logic          eg_a, eg_b, x, sb, we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    eg_a = 0; eg_b = 0;
    if (a_if.req && b_if.req) begin
      if (m_run < MAX_BURST) begin eg_a = (m_owner == 0); eg_b = (m_owner == 1); end
      else                   begin eg_a = (m_owner == 1); eg_b = (m_owner == 0); end
    end else begin
      eg_a = a_if.req; eg_b = b_if.req;
    end
    chk("a_gnt", 32'(a_if.gnt), 32'(eg_a));
    chk("b_gnt", 32'(b_if.gnt), 32'(eg_b));
    chk("ram_wr", 32'(ram_wr), 32'(e_wr));
    chk("ram_rd", 32'(ram_rd), 32'(e_rd));
    chk("ram_add", 32'(ram_add), 32'(e_add));
    chk("ram_din", 32'(ram_din), 32'(e_din));
    chk("a_rvalid", 32'(a_if.rvalid), 32'(e_arv));
    chk("b_rvalid", 32'(b_if.rvalid), 32'(e_brv));
    chk("a_rdata", 32'(a_if.rdata), 32'(e_ard));
    chk("b_rdata", 32'(b_if.rdata), 32'(e_brd));
    obs_ga = a_if.gnt; obs_gb = b_if.gnt; obs_wr = ram_wr; obs_rd = ram_rd;
    obs_add = ram_add; obs_din = ram_din;
    obs_arv = a_if.rvalid; obs_brv = b_if.rvalid; obs_ard = a_if.rdata; obs_brd = b_if.rdata;
    // read issued last cycle returns next cycle
    e_arv = 0; e_brv = 0;
    if (p_vld) begin
      if (p_port) begin e_brv = 1; e_brd = p_dat; end
      else        begin e_arv = 1; e_ard = p_dat; end
    end
    x  = eg_a | eg_b;
    sb = eg_b;
    we = sb ? b_if.we : a_if.we;
    ad = sb ? b_if.addr : a_if.addr;
    wd = sb ? b_if.wdata : a_if.wdata;
    p_vld = x & ~we; p_port = sb; p_dat = m_mem[ad];
    e_wr = x & we; e_rd = x & ~we;
    if (x) begin e_add = ad; e_din = wd; end
    if (x && we) m_mem[ad] = wd;
    if (x) begin
      if (m_run > 0 && sb == m_owner) m_run++;
      else begin m_owner = sb; m_run = 1; end
    end
  endtask

  task automatic cycle(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wdata = ad;
    b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wdata = bd;
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Asynchronous reset pulse inside a cycle: outputs must clear with no clock edge.
  task automatic reset_pulse();
    a_if.req = 0; b_if.req = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_rd", 32'(ram_rd), 32'd0);
    chk("rst_ram_add", 32'(ram_add), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_a_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
    chk("rst_a_rdata", 32'(a_if.rdata), 32'd0);
    chk("rst_b_rdata", 32'(b_if.rdata), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic          ar, aw, br, bw;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;
    logic          ega, egb, erva, ervb;
  } vec_t;

  vec_t vt [36];

  initial begin
    // contention reads (AAAABBBBAAAA), two idles, 20 cycles of B alone, two idles
    for (int i = 0; i < 36; i++) begin
      vt[i] = '{default: '0};
      if (i < 12) begin
        vt[i].ar = 1; vt[i].br = 1;
        vt[i].aa = 10'(i); vt[i].ba = 10'(256 + i);
        vt[i].ega = (i < 4) || (i >= 8);
        vt[i].egb = !vt[i].ega;
      end else if (i >= 14 && i < 34) begin
        vt[i].br = 1; vt[i].ba = 10'(i); vt[i].egb = 1;
      end
      if (i >= 2) begin
        vt[i].erva = vt[i-2].ega;
        vt[i].ervb = vt[i-2].egb;
      end
    end

    rst_n = 1'b0;
    a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ram_wr", 32'(ram_wr), 32'd0);
    chk("reset_ram_rd", 32'(ram_rd), 32'd0);
    chk("reset_a_rvalid", 32'(a_if.rvalid), 32'd0);
    chk("reset_b_rdata", 32'(b_if.rdata), 32'd0);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 36; i++) begin
      cycle(vt[i].ar, vt[i].aw, vt[i].aa, vt[i].ad, vt[i].br, vt[i].bw, vt[i].ba, vt[i].bd);
      chk("tbl_a_gnt", 32'(obs_ga), 32'(vt[i].ega));
      chk("tbl_b_gnt", 32'(obs_gb), 32'(vt[i].egb));
      chk("tbl_a_rvalid", 32'(obs_arv), 32'(vt[i].erva));
      chk("tbl_b_rvalid", 32'(obs_brv), 32'(vt[i].ervb));
    end

    // A writes 0x5A to 0x3FF, then reads it back
    cycle(1, 1, 10'h3FF, 8'h5A, 0, 0, '0, '0);
    chk("wr3ff_gnt", 32'(obs_ga), 32'd1);
    cycle(1, 0, 10'h3FF, 8'h00, 0, 0, '0, '0);
    chk("wr3ff_ram_wr", 32'(obs_wr), 32'd1);
    chk("wr3ff_ram_add", 32'(obs_add), 32'h3FF);
    chk("wr3ff_ram_din", 32'(obs_din), 32'h5A);
    idle();
    chk("rd3ff_ram_rd", 32'(obs_rd), 32'd1);
    idle();
    chk("rd3ff_a_rvalid", 32'(obs_arv), 32'd1);
    chk("rd3ff_a_rdata", 32'(obs_ard), 32'h5A);
    chk("rd3ff_b_rvalid", 32'(obs_brv), 32'd0);
    idle();
    chk("rd3ff_pulse_end", 32'(obs_arv), 32'd0);
    chk("rd3ff_rdata_hold", 32'(obs_ard), 32'h5A);

    // B writes 0x11 to 0x000, A reads 0x000 the very next cycle
    cycle(0, 0, '0, '0, 1, 1, 10'h000, 8'h11);
    chk("raw_b_gnt", 32'(obs_gb), 32'd1);
    cycle(1, 0, 10'h000, 8'h00, 0, 0, '0, '0);
    chk("raw_a_gnt", 32'(obs_ga), 32'd1);
    idle();
    idle();
    chk("raw_a_rvalid", 32'(obs_arv), 32'd1);
    chk("raw_a_rdata", 32'(obs_ard), 32'h11);

    // reset mid-stream while B owns the RAM; first contended grant after is A
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 1, 0, 10'(i + 5), '0);
    reset_pulse();
    cycle(1, 0, 10'h3FF, '0, 1, 0, 10'h001, '0);
    chk("post_rst_a_gnt", 32'(obs_ga), 32'd1);
    chk("post_rst_b_gnt", 32'(obs_gb), 32'd0);
    idle();
    chk("post_rst_no_b_rvalid", 32'(obs_brv), 32'd0);
    idle();
    chk("post_rst_a_rdata", 32'(obs_ard), 32'h5A);

    // read granted, reset in the next cycle: the read never returns
    cycle(1, 0, 10'h3FF, '0, 0, 0, '0, '0);
    chk("drop_a_gnt", 32'(obs_ga), 32'd1);
    reset_pulse();
    idle();
    idle();
    chk("drop_no_a_rvalid", 32'(obs_arv), 32'd0);
    chk("drop_a_rdata_zero", 32'(obs_ard), 32'd0);

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic          ar, aw, br, bw;
      logic [AW-1:0] aa, ba;
      ar = ($urandom_range(0, 9) < 7);
      br = ($urandom_range(0, 9) < 7);
      aw = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
      ba = ($urandom_range(0, 7) == 0) ? 10'h000 : 10'($urandom_range(0, 7));
      cycle(ar, aw, aa, 8'($urandom), br, bw, ba, 8'($urandom));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
